rr_arbiter_4: RTL and testbench

//   Round-robin arbiter sharing one downstream resource among 4 requesters.
//   The grant is held while the winner keeps its request, and is preempted after MAX_HOLD cycles if others wait.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 50 +++++
 rtl/rr_arbiter_4.sv | 125 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   N_REQ   number of requesters
//   IDX_W   width of an encoded requester index
//   state_e arbiter FSM states
//   onehot  index -> one-hot grant vector
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
// Finds the first set request scanning last_ptr+1, last_ptr+2, ... (mod 4),
// optionally ignoring one requester.
//   req       in  4  request vector
//   last_ptr  in  2  most recent winner; it has lowest priority
//   excl_en   in  1  ignore requester excl_idx
//   excl_idx  in  2  requester to ignore when excl_en
//   any       out 1  some eligible request exists
//   idx       out 2  winning requester (don't-care when !any)
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] off;

    // Scan start; 2-bit arithmetic wraps mod 4 for free.
    assign base = last_ptr + IDX_W'(1);

    always_comb begin
        masked = req;
        if (excl_en) masked[excl_idx] = 1'b0;
    end

    // rot[0] is the highest-priority requester for this round.
    for (genvar i = 0; i < N_REQ; i++) begin : g_rot
        assign rot[i] = masked[base + IDX_W'(i)];
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign any = |rot;
    assign idx = base + off;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters sharing one resource.
// The winner keeps the grant while it requests; after MAX_HOLD consecutive
// contended cycles it is preempted in favour of the next waiting requester.
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   req        in  4  request per requester
//   gnt        out 4  registered one-hot grant, 0 when idle
//   gnt_idx    out 2  registered index of the granted requester, 0 when idle
//   gnt_valid  out 1  registered, equals |gnt
//   preempt    out 1  one-cycle pulse with the grant that a timeout forced
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    state_e            state, state_nxt;
    logic [IDX_W-1:0]  last_ptr, last_ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [IDX_W-1:0]  gnt_idx_nxt;
    logic              preempt_nxt;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              holder_req;
    logic              others;
    logic              hold_last;

    // While granting, the holder is excluded so a timeout moves on. On a
    // release the holder's request is already low, so the exclusion is moot.
    rr_pick4 u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .excl_en  (state == ST_GRANT),
        .excl_idx (gnt_idx),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    assign holder_req = req[gnt_idx];
    assign others     = |(req & ~gnt);
    assign hold_last  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_ptr  <= IDX_W'(N_REQ - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_ptr  <= last_ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= |gnt_nxt;
            preempt   <= preempt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_ptr_nxt = last_ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        gnt_idx_nxt  = gnt_idx;
        preempt_nxt  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt    = ST_GRANT;
                    gnt_nxt      = onehot(pick_idx);
                    gnt_idx_nxt  = pick_idx;
                    last_ptr_nxt = pick_idx;
                    hold_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (!holder_req) begin
                    // Release: hand over in the same edge when possible.
                    hold_cnt_nxt = '0;
                    if (pick_any) begin
                        gnt_nxt      = onehot(pick_idx);
                        gnt_idx_nxt  = pick_idx;
                        last_ptr_nxt = pick_idx;
                    end else begin
                        state_nxt   = ST_IDLE;
                        gnt_nxt     = '0;
                        gnt_idx_nxt = '0;
                    end
                end else if (!others) begin
                    // Uncontended holding never counts toward a timeout.
                    hold_cnt_nxt = '0;
                end else if (hold_last) begin
                    gnt_nxt      = onehot(pick_idx);
                    gnt_idx_nxt  = pick_idx;
                    last_ptr_nxt = pick_idx;
                    hold_cnt_nxt = '0;
                    preempt_nxt  = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    // Model state: holder (-1 idle), last winner, contended hold count, preempt flag.
    int m_h    = -1;
    int m_last = 3;
    int m_cnt  = 0;
    bit m_pre  = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // First requester after 'last' in circular order, skipping 'excl'; -1 if none.
    function automatic int pick_m(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_gnt();
        return (m_h < 0) ? 0 : (1 << m_h);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h    <= -1;
            m_last <= 3;
            m_cnt  <= 0;
            m_pre  <= 1'b0;
        end else begin
            int nh, nl, nc, p;
            bit np, oth;
            nh = m_h; nl = m_last; nc = m_cnt; np = 1'b0;
            oth = 1'b0;
            for (int i = 0; i < 4; i++) if (i != m_h && req[i]) oth = 1'b1;
            if (m_h < 0) begin
                p = pick_m(req, m_last, -1);
                if (p >= 0) begin nh = p; nl = p; nc = 0; end
            end else if (!req[m_h]) begin
                p = pick_m(req, m_h, -1);
                nh = p; nc = 0;
                if (p >= 0) nl = p;
            end else if (!oth) begin
                nc = 0;
            end else if (m_cnt == MAXH - 1) begin
                p = pick_m(req, m_h, m_h);
                nh = p; nl = p; nc = 0; np = 1'b1;
            end else begin
                nc = m_cnt + 1;
            end
            m_h <= nh; m_last <= nl; m_cnt <= nc; m_pre <= np;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("model_gnt", gnt, m_gnt());
            chk("model_idx", gnt_idx, (m_h < 0) ? 0 : m_h);
            chk("model_valid", gnt_valid, (m_h >= 0));
            chk("model_preempt", preempt, m_pre);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [3:0] g, input int i, input bit p);
        chk({nm, "_gnt"}, gnt, g);
        chk({nm, "_idx"}, gnt_idx, i);
        chk({nm, "_valid"}, gnt_valid, |g);
        chk({nm, "_preempt"}, preempt, p);
        chk({nm, "_modelpin"}, m_gnt(), g);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        cyc(2);
        lit("por", 4'b0000, 0, 0);
        rst_n = 1'b1;
        run   = 1'b1;
        cyc(1);
        lit("idle", 4'b0000, 0, 0);

        // Single request and release.
        req = 4'b0100; cyc(1); lit("single", 4'b0100, 2, 0);
        req = 4'b0000; cyc(1); lit("single_rel", 4'b0000, 0, 0);

        // Wrap past the top after a grant to requester 1.
        req = 4'b0010; cyc(1); lit("pre_skip", 4'b0010, 1, 0);
        req = 4'b0000; cyc(1); lit("pre_skip_rel", 4'b0000, 0, 0);
        req = 4'b0001; cyc(1); lit("skip", 4'b0001, 0, 0);
        req = 4'b0000; cyc(1);

        // Lone requester is never preempted.
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            cyc(1); lit("alone", 4'b1000, 3, 0);
        end
        req = 4'b0000; cyc(1); lit("alone_rel", 4'b0000, 0, 0);

        // Timeout preemption both ways.
        req = 4'b0011;
        for (int i = 0; i < MAXH; i++) begin
            cyc(1); lit("hold0", 4'b0001, 0, 0);
        end
        cyc(1); lit("preempt_to1", 4'b0010, 1, 1);
        for (int i = 1; i < MAXH; i++) begin
            cyc(1); lit("hold1", 4'b0010, 1, 0);
        end
        cyc(1); lit("preempt_to0", 4'b0001, 0, 1);

        // Asynchronous reset mid-grant.
        req = 4'b1111; cyc(2);
        rst_n = 1'b0;
        #1 lit("async_rst", 4'b0000, 0, 0);
        #1 rst_n = 1'b1;
        cyc(1); lit("post_rst", 4'b0001, 0, 0);

        // Rotation: each holder drops for a cycle, no idle bubble.
        req = 4'b1110; cyc(1); lit("rot1", 4'b0010, 1, 0);
        req = 4'b1101; cyc(1); lit("rot2", 4'b0100, 2, 0);
        req = 4'b1011; cyc(1); lit("rot3", 4'b1000, 3, 0);
        req = 4'b0111; cyc(1); lit("rot0", 4'b0001, 0, 0);

        req = 4'b0000; cyc(2);
        lit("end_idle", 4'b0000, 0, 0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
